// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1 frames behind a four-phase req/ack handshake.
// Optional even parity bit is compiled in with the macro UART_TX_PARITY_EN.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 18
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req,
  input  logic [7:0] data,
  output logic       ack,
  output logic       xmt,
  output logic       busy
);

  localparam int unsigned  CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          xmt_q, xmt_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          bit_done;
  logic          accept;

  assign bit_done = (cnt_q == CNT_LAST);
  assign accept   = (state_q == S_IDLE) && req && !ack_q;

  // State, bit timer, handshake and line registers; clr abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      xmt_q   <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      xmt_q   <= xmt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: xmt_d is the value the line carries for the upcoming bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    xmt_d   = xmt_q;
    ack_d   = ack_q;

    // ack drop has priority; it cannot coincide with an accept since accept needs ack_q=0
    if (ack_q && !req) begin
      ack_d = 1'b0;
    end else if (accept) begin
      ack_d = 1'b1;
    end else begin
      ack_d = ack_q;
    end

    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        xmt_d = 1'b1;
        if (accept) begin
          shreg_d = data;
          state_d = S_START;
          xmt_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          xmt_d   = shreg_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            xmt_d   = ^shreg_q;
`else
            state_d = S_STOP;
            xmt_d   = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            xmt_d = shreg_q[idx_q + 3'd1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          xmt_d   = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          xmt_d   = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        xmt_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ack  = ack_q;
  assign xmt  = xmt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomized checks of uart_transmitter against a frame-level reference model.
module tb_uart_transmitter;

  localparam int CPB = 18;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk;
  logic       clr;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       xmt;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .clr  (clr),
    .req  (req),
    .data (data),
    .ack  (ack),
    .xmt  (xmt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Line level of bit-slot i of the frame carrying byte b (slot 0 = start bit).
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {2'b11, b, 1'b0};
`endif
    return f[i];
  endfunction

  // Send one frame starting from IDLE; optionally hold req, or re-raise it with next_b at cycle reraise_at.
  task automatic do_frame(input logic [7:0] b, input bit hold, input int reraise_at, input logic [7:0] next_b);
    data = b;
    req  = 1'b1;
    tick();
    for (int t = 0; t < FL; t++) begin
      check("xmt_bit", xmt, exp_bit(b, t / CPB));
      check("busy_frame", busy, 1'b1);
      if (t == 0) check("ack_rise", ack, 1'b1);
      if (hold) begin
        if (t % CPB == 5) check("ack_held", ack, 1'b1);
      end else begin
        if (t == 0) begin
          req  = 1'b0;
          data = 8'($urandom);
        end
        if (t == 1) check("ack_drop", ack, 1'b0);
        if (t == reraise_at) begin
          req  = 1'b1;
          data = next_b;
        end
      end
      tick();
    end
    check("busy_end", busy, 1'b0);
    check("xmt_end", xmt, 1'b1);
    if (hold) begin
      for (int k = 0; k < 2 * CPB; k++) begin
        check("hold_no_restart", xmt, 1'b1);
        check("hold_busy", busy, 1'b0);
        check("hold_ack", ack, 1'b1);
        tick();
      end
      req = 1'b0;
      tick();
      check("hold_ack_drop", ack, 1'b0);
      check("hold_idle", busy, 1'b0);
    end else if (reraise_at < 0) begin
      check("ack_end", ack, 1'b0);
    end else begin
      check("pending_ack", ack, 1'b0);
    end
  endtask

  initial begin
    clr  = 1'b1;
    req  = 1'b0;
    data = 8'h00;
    tick();
    tick();
    check("rst_xmt", xmt, 1'b1);
    check("rst_ack", ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_xmt", xmt, 1'b1);
      check("idle_ack", ack, 1'b0);
      check("idle_busy", busy, 1'b0);
    end

    // clr wins over a simultaneous accept
    clr  = 1'b1;
    req  = 1'b1;
    data = 8'h3C;
    tick();
    check("clr_accept_ack", ack, 1'b0);
    check("clr_accept_busy", busy, 1'b0);
    check("clr_accept_xmt", xmt, 1'b1);
    clr = 1'b0;
    req = 1'b0;
    tick();
    check("clr_accept_idle", busy, 1'b0);

    do_frame(8'h12, 1'b0, -1, 8'h00);
    tick();
    do_frame(8'h13, 1'b0, -1, 8'h00);
    tick();
    do_frame(8'hA5, 1'b1, -1, 8'h00);
    tick();

    // Mid-frame clear at cycle 50 of a 0xFF frame
    data = 8'hFF;
    req  = 1'b1;
    tick();
    for (int t = 0; t < 50; t++) begin
      check("ff_xmt", xmt, exp_bit(8'hFF, t / CPB));
      check("ff_busy", busy, 1'b1);
      if (t == 0) req = 1'b0;
      if (t < 49) tick();
    end
    clr = 1'b1;
    tick();
    check("midclr_xmt", xmt, 1'b1);
    check("midclr_busy", busy, 1'b0);
    check("midclr_ack", ack, 1'b0);
    clr = 1'b0;
    tick();
    check("midclr_idle", busy, 1'b0);
    do_frame(8'h00, 1'b0, -1, 8'h00);
    tick();

    // Back-to-back with a pending re-raised request: second start 181 cycles after the first
    do_frame(8'h55, 1'b0, 90, 8'hAA);
    do_frame(8'hAA, 1'b0, -1, 8'h00);
    tick();

    for (int n = 0; n < 4; n++) begin
      logic [7:0] rb;
      logic [7:0] nb;
      rb = 8'($urandom);
      nb = 8'($urandom);
      if (n % 2 == 1) begin
        do_frame(rb, 1'b0, int'($urandom_range(2, FL - 1)), nb);
        do_frame(nb, 1'b0, -1, 8'h00);
      end else begin
        do_frame(rb, 1'b0, -1, 8'h00);
      end
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
